pulse_window_ctrl: RTL and testbench

- Sequences the pulse monitor's averaging datapath: counts single-cycle heartbeat pulses over fixed-length windows and keeps the last four window counts in a history register.
- Presents the four counts (6-bit each) to the downstream 4-sample averager, plus a valid flag and a per-window update strobe.
- Sits between the synchronized/debounced pulse input and the averager/display logic.

---
 rtl/pulse_window_ctrl.sv | 123 ++++++++++++
 tb/tb_pulse_window_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_window_ctrl.sv
// Window sequencer for the pulse monitor: counts beats per fixed-length window
// and keeps the last four window counts for the downstream 4-sample averager.
module pulse_window_ctrl #(
  parameter int WINDOW_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pulse_in,
  output logic [5:0] count1,
  output logic [5:0] count2,
  output logic [5:0] count3,
  output logic [5:0] count4,
  output logic       win_done,
  output logic       avg_valid
);

  localparam int            TW       = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0] LAST_CYC = TW'(WINDOW_CYCLES - 1);
  localparam logic [5:0]    CNT_MAX  = 6'd63;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [5:0]    live, live_next;
  logic [1:0]    fill, fill_next;
  logic [5:0]    count1_next, count2_next, count3_next, count4_next;
  logic          win_done_next, avg_valid_next;
  logic [5:0]    live_inc;
  logic          window_end;

  // Saturating count including this cycle's pulse; also feeds count1 at window end.
  assign live_inc   = (pulse_in && live != CNT_MAX) ? live + 6'd1 : live;
  assign window_end = (timer == LAST_CYC);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_next     = state;
    timer_next     = timer;
    live_next      = live;
    fill_next      = fill;
    count1_next    = count1;
    count2_next    = count2;
    count3_next    = count3;
    count4_next    = count4;
    win_done_next  = 1'b0;
    avg_valid_next = avg_valid;

    if (!enable) begin
      // Dropping enable beats a coincident window end: no update, no strobe.
      state_next     = IDLE;
      timer_next     = '0;
      live_next      = '0;
      fill_next      = '0;
      count1_next    = '0;
      count2_next    = '0;
      count3_next    = '0;
      count4_next    = '0;
      avg_valid_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = FILL;
          timer_next = '0;
          live_next  = '0;
        end
        FILL, RUN: begin
          if (window_end) begin
            timer_next    = '0;
            live_next     = '0;
            count4_next   = count3;
            count3_next   = count2;
            count2_next   = count1;
            count1_next   = live_inc;
            win_done_next = 1'b1;
            if (state == FILL) begin
              fill_next = fill + 2'd1;
              if (fill == 2'd3) begin
                state_next     = RUN;
                avg_valid_next = 1'b1;
              end
            end
          end else begin
            timer_next = timer + TW'(1);
            live_next  = live_inc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      live      <= '0;
      fill      <= '0;
      count1    <= '0;
      count2    <= '0;
      count3    <= '0;
      count4    <= '0;
      win_done  <= 1'b0;
      avg_valid <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      live      <= live_next;
      fill      <= fill_next;
      count1    <= count1_next;
      count2    <= count2_next;
      count3    <= count3_next;
      count4    <= count4_next;
      win_done  <= win_done_next;
      avg_valid <= avg_valid_next;
    end
  end

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Scoreboard bench for pulse_window_ctrl: one instance with 8-cycle windows,
// one with 80-cycle windows for the saturation case.
module tb_pulse_window_ctrl;

  logic clk;
  logic rst;
  logic en8, p8, en80, p80;
  logic [5:0] a1, a2, a3, a4, b1, b2, b3, b4;
  logic wd8, av8, wd80, av80;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int c1, c2, c3, c4, av, cyc;
  } exp_t;

  exp_t sb8[$];
  exp_t sb80[$];
  int   hist[2][4];
  int   fill[2];

  pulse_window_ctrl #(.WINDOW_CYCLES(8)) dut8 (
    .clk(clk), .rst(rst), .enable(en8), .pulse_in(p8),
    .count1(a1), .count2(a2), .count3(a3), .count4(a4),
    .win_done(wd8), .avg_valid(av8)
  );

  pulse_window_ctrl #(.WINDOW_CYCLES(80)) dut80 (
    .clk(clk), .rst(rst), .enable(en80), .pulse_in(p80),
    .count1(b1), .count2(b2), .count3(b3), .count4(b4),
    .win_done(wd80), .avg_valid(av80)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic e, input logic p);
    if (sel == 0) begin en8 = e; p8 = p; end
    else begin en80 = e; p80 = p; end
  endtask

  task automatic clear_model(input int sel);
    for (int k = 0; k < 4; k++) hist[sel][k] = 0;
    fill[sel] = 0;
  endtask

  task automatic check_zero(input int sel, input string tag);
    if (sel == 0) begin
      check({tag, "_c1"}, int'(a1), 0);
      check({tag, "_c2"}, int'(a2), 0);
      check({tag, "_c3"}, int'(a3), 0);
      check({tag, "_c4"}, int'(a4), 0);
      check({tag, "_wd"}, int'(wd8), 0);
      check({tag, "_av"}, int'(av8), 0);
    end else begin
      check({tag, "_c1"}, int'(b1), 0);
      check({tag, "_c2"}, int'(b2), 0);
      check({tag, "_c3"}, int'(b3), 0);
      check({tag, "_c4"}, int'(b4), 0);
      check({tag, "_wd"}, int'(wd80), 0);
      check({tag, "_av"}, int'(av80), 0);
    end
  endtask

  // Expected history after a window closing at the next edge with count c.
  task automatic push_window(input int sel, input int c);
    exp_t e;
    for (int k = 3; k > 0; k--) hist[sel][k] = hist[sel][k-1];
    hist[sel][0] = c;
    if (fill[sel] < 4) fill[sel]++;
    e.c1  = hist[sel][0];
    e.c2  = hist[sel][1];
    e.c3  = hist[sel][2];
    e.c4  = hist[sel][3];
    e.av  = (fill[sel] == 4) ? 1 : 0;
    e.cyc = cyc + 1;
    if (sel == 0) sb8.push_back(e);
    else sb80.push_back(e);
  endtask

  task automatic start_fill(input int sel);
    drive(sel, 1'b1, 1'b0);
    tick();
  endtask

  // One full window; pulses occupy the first (or last) npulse cycles.
  task automatic run_window(input int sel, input int ncyc, input int npulse, input bit at_end);
    int   cnt;
    logic p;
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      p = at_end ? (i >= ncyc - npulse) : (i < npulse);
      drive(sel, 1'b1, p);
      cnt += int'(p);
      if (i == ncyc - 1) push_window(sel, (cnt > 63) ? 63 : cnt);
      tick();
    end
    drive(sel, 1'b1, 1'b0);
  endtask

  task automatic pop_check(input int sel);
    exp_t  e;
    string s;
    s = (sel == 0) ? "w8" : "w80";
    if ((sel == 0 && sb8.size() == 0) || (sel == 1 && sb80.size() == 0)) begin
      check({s, "_unexpected_win_done"}, 1, 0);
    end else begin
      if (sel == 0) begin
        e = sb8.pop_front();
        check({s, "_c1"}, int'(a1), e.c1);
        check({s, "_c2"}, int'(a2), e.c2);
        check({s, "_c3"}, int'(a3), e.c3);
        check({s, "_c4"}, int'(a4), e.c4);
        check({s, "_av"}, int'(av8), e.av);
      end else begin
        e = sb80.pop_front();
        check({s, "_c1"}, int'(b1), e.c1);
        check({s, "_c2"}, int'(b2), e.c2);
        check({s, "_c3"}, int'(b3), e.c3);
        check({s, "_c4"}, int'(b4), e.c4);
        check({s, "_av"}, int'(av80), e.av);
      end
      check({s, "_wd_cycle"}, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wd8)  pop_check(0);
      if (wd80) pop_check(1);
    end
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    clear_model(0);
    clear_model(1);
    #2;
    check_zero(0, "rst8");
    check_zero(1, "rst80");
    tick();
    rst = 1'b0;

    // Disabled: pulses ignored.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 1'b1);
      tick();
      check_zero(0, "idle_pulse");
    end

    // Fill with 3/5/7/8, then an empty window in RUN.
    start_fill(0);
    run_window(0, 8, 3, 1'b0);
    run_window(0, 8, 5, 1'b0);
    run_window(0, 8, 7, 1'b0);
    run_window(0, 8, 8, 1'b0);
    run_window(0, 8, 0, 1'b0);

    // One-cycle enable drop in RUN, then four fresh windows.
    drive(0, 1'b0, 1'b0);
    tick();
    check_zero(0, "drop1");
    clear_model(0);
    start_fill(0);
    run_window(0, 8, 1, 1'b1);
    run_window(0, 8, 0, 1'b0);
    run_window(0, 8, 2, 1'b0);
    run_window(0, 8, 4, 1'b0);

    // Enable falls on the window-end cycle with a pulse: clear wins.
    for (int i = 0; i < 8; i++) begin
      drive(0, (i < 7), (i >= 5));
      tick();
    end
    check_zero(0, "drop_end");
    clear_model(0);
    tick();
    check_zero(0, "drop_end_next");

    // Async reset mid-window with non-zero history.
    start_fill(0);
    run_window(0, 8, 6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b1);
      tick();
    end
    check("pre_rst_c1", int'(a1), 6);
    rst = 1'b1;
    #1;
    check_zero(0, "async_rst");
    clear_model(0);
    drive(0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_zero(0, "post_rst_idle");
    end

    // Saturation with 80-cycle windows, then a restart from 0.
    start_fill(1);
    run_window(1, 80, 80, 1'b0);
    run_window(1, 80, 10, 1'b1);
    drive(1, 1'b0, 1'b0);
    tick();
    tick();

    check("sb8_empty", sb8.size(), 0);
    check("sb80_empty", sb80.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
